// File: rtl/clint_top.sv
// Core-local interruptor: mtime/mtimecmp/msip registers behind a one-outstanding
// request/response bus, producing the machine timer and software interrupt lines.
module clint_top #(
  parameter int                DATA_W       = 64,
  parameter int                ADDR_W       = 16,
  parameter int                TICK_DIV     = 1,
  parameter logic [ADDR_W-1:0] MSIP_OFF     = 16'h0000,
  parameter logic [ADDR_W-1:0] MTIMECMP_OFF = 16'h4000,
  parameter logic [ADDR_W-1:0] MTIME_OFF    = 16'hBFF8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                clint_mtip,
  output logic                clint_msip
);

  // state  | meaning
  // S_IDLE | ready for a request; accepted request is executed on the same edge
  // S_RESP | response held on the bus until rsp_ready
  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  localparam int          STRB_W    = DATA_W / 8;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_mtime;
  logic [DATA_W-1:0]   r_mtimecmp;
  logic                r_msip;
  logic                r_mtip;
  logic [15:0]         r_presc;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_hit_msip;
  logic                w_hit_cmp;
  logic                w_hit_mtime;
  logic                w_err;
  logic                w_accept;
  logic                w_wr;
  logic                w_wrap;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_rd;
  logic [DATA_W-1:0]   w_mtime_nx;
  logic [DATA_W-1:0]   w_cmp_nx;
  logic                w_msip_nx;

  assign w_hit_msip  = (req_addr == MSIP_OFF);
  assign w_hit_cmp   = (req_addr == MTIMECMP_OFF);
  assign w_hit_mtime = (req_addr == MTIME_OFF);
  assign w_err       = (req_addr[2:0] != 3'b000) ||
                       !(w_hit_msip || w_hit_cmp || w_hit_mtime);

  // req_ready is gated by rst so the bus sees "not ready" during reset
  assign req_ready = rst && (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign w_accept  = req_valid && req_ready;
  assign w_wr      = w_accept && req_write && !w_err;
  assign w_wrap    = (r_presc == TICK_LAST);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      w_mask[8*i +: 8] = {8{req_wstrb[i]}};
    end
  end

  assign w_mtime_nx = (r_mtime & ~w_mask) | (req_wdata & w_mask);
  assign w_cmp_nx   = (r_mtimecmp & ~w_mask) | (req_wdata & w_mask);
  assign w_msip_nx  = req_wstrb[0] ? req_wdata[0] : r_msip;

  always_comb begin
    w_rd = '0;
    if (!req_write && !w_err) begin
      if (w_hit_msip) begin
        w_rd = {{(DATA_W-1){1'b0}}, r_msip};
      end else if (w_hit_cmp) begin
        w_rd = r_mtimecmp;
      end else if (w_hit_mtime) begin
        w_rd = r_mtime;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_wrap ? 16'd0 : r_presc + 16'd1;
    end
  end

  // A bus write to mtime takes priority over a coincident tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime <= '0;
    end else if (w_wr && w_hit_mtime) begin
      r_mtime <= w_mtime_nx;
    end else if (w_wrap) begin
      r_mtime <= r_mtime + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr && w_hit_cmp) begin
        r_mtimecmp <= w_cmp_nx;
      end
      if (w_wr && w_hit_msip) begin
        r_msip <= w_msip_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= w_rd;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign clint_mtip = r_mtip;
  assign clint_msip = r_msip;

endmodule
